// File: rtl/inv_sub_shift_serial.sv
// Byte-serial AES InvShiftRows + InvSubBytes over a 128-bit state.
// One shared inverse S-box processes one result byte per clock, with a valid/ready handshake on both sides.

module inv_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        acc = acc ^ sh;
      end else begin
        acc = acc;
      end
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // x^254 is the multiplicative inverse, and it maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] acc;
    p   = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      acc = gf_mul(acc, p);
    end
    return acc;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

  assign out_byte = gf_inv(inv_affine(in_byte));

endmodule

module inv_sub_shift_serial (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] src_q, src_d;
  logic [127:0] res_q, res_d;

  logic [1:0]   src_col_s;
  logic [3:0]   src_idx_s;
  logic [7:0]   sbox_in_s;
  logic [7:0]   sbox_out_s;

  inv_sbox u_inv_sbox (
    .in_byte  (sbox_in_s),
    .out_byte (sbox_out_s)
  );

  // Source byte for result byte cnt=4c+r is column (c-r) mod 4 of the same row; byte k sits at bit offset 8*(15-k)
  always_comb begin
    src_col_s = cnt_q[3:2] - cnt_q[1:0];
    src_idx_s = {src_col_s, cnt_q[1:0]};
    sbox_in_s = src_q[{~src_idx_s, 3'b000} +: 8];
  end

  // Next-state, counter and datapath register updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          src_d   = in_data;
          cnt_d   = 4'd0;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        res_d[{~cnt_q, 3'b000} +: 8] = sbox_out_s;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      src_q   <= 128'h0;
      res_q   <= 128'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = res_q;

endmodule

// File: tb/tb_inv_sub_shift_serial.sv
// Directed and randomized bench for inv_sub_shift_serial, checked against a table-driven
// InvShiftRows + InvSubBytes reference model.

module tb_inv_sub_shift_serial;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] isb [256];

  inv_sub_shift_serial dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Arrange as a 4x4 row/column matrix, rotate row r right by r, substitute each byte.
  function automatic logic [127:0] model(input logic [127:0] x);
    logic [7:0]   m [4][4];
    logic [127:0] y;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[r][c] = x[127 - 8 * (4 * c + r) -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[127 - 8 * (4 * c + r) -: 8] = isb[m[r][(c + 4 - r) % 4]];
    return y;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer d from IDLE, wait for the result, hold it for 'stall' cycles, then release it.
  task automatic run_txn(input string tag, input logic [127:0] d, input logic [127:0] exp, input int stall);
    int lat;
    chk({tag, "_idle_ready"}, 128'(in_ready), 128'd1);
    in_data  = d;
    in_valid = 1'b1;
    step();
    lat = 0;
    while (!out_valid && lat < 40) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = rnd128();
      out_ready = 1'($urandom_range(0, 1));
      step();
      lat++;
    end
    chk({tag, "_latency"}, 128'(lat), 128'd16);
    chk({tag, "_result"}, out_data, exp);
    for (int i = 0; i < stall; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = rnd128();
      out_ready = 1'b0;
      step();
      chk({tag, "_hold"}, {out_data, out_valid, in_ready}, {exp, 1'b1, 1'b0});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_release"}, {126'd0, out_valid, in_ready}, 128'd1);
  endtask

  initial begin
    int            t0;
    int            lat;
    logic [127:0]  a;
    logic [127:0]  b;
    logic [127:0]  d;

    isb = '{
      8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
      8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
      8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
      8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
      8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
      8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
      8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
      8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
      8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
      8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
      8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
      8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
      8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
      8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
      8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
      8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
    };

    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = rnd128();
    step();
    step();
    chk("reset_state", {out_data, out_valid, in_ready, busy}, {128'h0, 1'b0, 1'b1, 1'b0});
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Fixed vectors with independently known answers
    run_txn("zero", 128'h0, {16{8'h52}}, 0);
    run_txn("fips", 128'h000102030405060708090a0b0c0d0e0f,
            128'h52f3a3383009d79ebf366afb8140a5d5, 2);
    run_txn("all63", {16{8'h63}}, 128'h0, 10);

    // Abort in the middle of BUSY with competing inputs
    a = rnd128();
    in_data  = a;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("abort_busy_before", 128'(busy), 128'd1);
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("abort_state", {out_data, out_valid, in_ready, busy}, {128'h0, 1'b0, 1'b1, 1'b0});
    d = rnd128();
    run_txn("after_abort", d, model(d), 1);

    // Back-to-back with in_valid held high: next accept one cycle after the output handshake
    a = rnd128();
    b = rnd128();
    in_data   = a;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_data = b;
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    chk("b2b_latency", 128'(lat), 128'd16);
    chk("b2b_first", out_data, model(a));
    step();
    chk("b2b_idle", {126'd0, out_valid, in_ready}, 128'd1);
    step();
    chk("b2b_second_accepted", {126'd0, busy, in_ready}, 128'd2);
    in_valid = 1'b0;
    t0 = 0;
    while (!out_valid && t0 < 40) begin
      step();
      t0++;
    end
    chk("b2b_second_latency", 128'(t0), 128'd16);
    chk("b2b_second", out_data, model(b));
    step();
    out_ready = 1'b0;
    chk("b2b_done", {126'd0, out_valid, in_ready}, 128'd1);

    // Randomized states with random stalls
    for (int n = 0; n < 1000; n++) begin
      d = rnd128();
      run_txn("rand", d, model(d), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inv_sub_shift_serial.md
INV_SUB_SHIFT_SERIAL -- requirements
Module: inv_sub_shift_serial

Interface
REQ-001 SHALL have no parameters; state width fixed at 128 bits, byte lane 8 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream offers in_data this cycle.
REQ-005 in_ready  output  1  block can accept a new state.
REQ-006 in_data  input  128  AES state; byte k = bits [127-8k -: 8], byte index k = 4c+r (column-major, FIPS-197).
REQ-007 out_valid  output  1  out_data holds a completed result.
REQ-008 out_ready  input  1  downstream accepts out_data.
REQ-009 out_data  output  128  InvSubBytes(InvShiftRows(in_data)), same byte mapping as in_data.
REQ-010 busy  output  1  high in BUSY and DONE states.

Function
REQ-011 SHALL contain exactly one inv_sbox instance, used byte-serially, one byte per cycle.
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE; only these three are reachable.
REQ-013 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready, capture in_data into input register, clear 4-bit counter cnt to 0, go to BUSY.
REQ-014 BUSY: in_ready=0; each cycle write result byte cnt = inv_sbox(src byte 4*((c-r) mod 4)+r), where cnt=4c+r; increment cnt.
REQ-015 BUSY with cnt==15: write last byte, go to DONE next edge; cnt wraps to 0, never exceeds 15.
REQ-016 DONE: out_valid=1, out_data = result register, in_ready=0; on out_ready go to IDLE.
REQ-017 Latency: accept edge at cycle 0 -> BUSY cycles 1..16 -> out_valid=1 from cycle 17; minimum accept-to-accept interval 18 cycles.
REQ-018 out_data SHALL remain stable while out_valid=1 and out_ready=0 (indefinite backpressure).
REQ-019 in_valid and in_data SHALL be ignored in BUSY and DONE; no capture, no state change.
REQ-020 Captured input register SHALL NOT change during BUSY even if in_data changes.
REQ-021 out_ready while out_valid=0 SHALL have no effect.
REQ-022 out_data SHALL be driven from the result register only (no combinational path from in_data).
REQ-023 busy SHALL equal (state != IDLE).

Reset
REQ-024 rst=1 at a rising edge SHALL force state=IDLE, cnt=0, input and result registers=0, from the next cycle.
REQ-025 Reset values: in_ready=1, out_valid=0, busy=0, out_data=128'h0.
REQ-026 rst SHALL override all other inputs, including simultaneous in_valid or out_ready, and abort any BUSY/DONE operation; aborted result SHALL never be presented.
REQ-027 First capture after reset SHALL be possible on the first edge with rst=0 and in_valid=1.

Verification
REQ-028 in_data=128'h00..00, out_ready=1 -> out_valid at cycle 17, out_data=128'h5252...52 (all bytes 0x52).
REQ-029 in_data=128'h000102030405060708090a0b0c0d0e0f -> out_data=128'h52f3a3383009d79ebf366afb8140a5d5.
REQ-030 in_data all 0x63, out_ready=0 for 10 cycles after out_valid -> out_data=0 held stable, in_ready=0 throughout; in_valid pulses during BUSY/DONE ignored.
REQ-031 rst asserted at cycle 8 of BUSY -> next cycle in_ready=1, out_valid=0, out_data=0; following new input completes normally with correct result.
REQ-032 Two back-to-back inputs with in_valid held high, out_ready=1 -> second accepted exactly one cycle after first out_valid/out_ready handshake; both results correct.
REQ-033 Random 128-bit states (>=1000) with random out_ready stalls -> each output matches software InvShiftRows+InvSubBytes model; no drops, no duplicates.
